// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: shared types and constants for the serial pattern transmitter
// and the sequence-detector FSMs it feeds.
//   state_e             : transmitter FSM states
//   DEFAULT_PRE_W       : default preamble length in bits
//   DEFAULT_PRE_PATTERN : default preamble, sent MSB-first
//   clog2 / max_int     : elaboration-time sizing helpers
package seq_pattern_pkg;

  typedef enum logic [2:0] {IDLE, PRE, DATA, PARITY, GAP} state_e;

  localparam int DEFAULT_PRE_W = 4;
  localparam logic [DEFAULT_PRE_W-1:0] DEFAULT_PRE_PATTERN = 4'b1011;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: word handshake and serial-stream bundle of seq_pattern_tx.
//   in_valid / in_data / in_ready : one word per valid&ready handshake
//   Z                             : serial output bit
//   z_active                      : Z carries a frame bit
//   busy                          : frame or gap in progress
//   done                          : one-cycle pulse at end of frame
// master: word source / stream observer; slave: the transmitter.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              Z;
  logic              z_active;
  logic              busy;
  logic              done;

  modport master (
    output in_valid, in_data,
    input  in_ready, Z, z_active, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, Z, z_active, busy, done
  );
endinterface

// File: rtl/seq_bit_timer.sv
// seq_bit_timer: paces serial bits, each lasting CLKS_PER_BIT clk cycles.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   restart  : hold the timer at the start of a bit
//   bit_tick : high on the last cycle of each bit
module seq_bit_timer
  import seq_pattern_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int TW = clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  // Wrapping on the last cycle means the next bit starts immediately,
  // so no cycle is lost at bit or state boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign bit_tick = !restart && (r_cnt == LAST);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial frame transmitter feeding sequence-detector FSMs.
// Frame = preamble (MSB-first), data (MSB-first), optional even parity,
// then GAP_BITS bit-times of Z=0, then a one-cycle done pulse.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : seq_pattern_tx_if.slave (word handshake + serial outputs)
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int               DATA_W       = 8,
  parameter int               PRE_W        = DEFAULT_PRE_W,
  parameter logic [PRE_W-1:0] PRE_PATTERN  = DEFAULT_PRE_PATTERN,
  parameter int               CLKS_PER_BIT = 1,
  parameter int               PARITY_EN    = 1,
  parameter int               GAP_BITS     = 1
) (
  input logic              clk,
  input logic              reset_n,
  seq_pattern_tx_if.slave  bus
);

  localparam int CNT_W = clog2(max_int(max_int(PRE_W, DATA_W), max_int(GAP_BITS, 1)) + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_e            r_state, w_state_next;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
  logic [PRE_W-1:0]  r_pre, w_pre_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic              r_parity, w_parity_next;
  logic              r_z, w_z_next;
  logic              r_z_active, w_z_active_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              w_frame_end;
  logic              w_bit_tick;

  // Timer is parked while idle so the first preamble bit gets a full bit-time.
  seq_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart  (r_state == IDLE),
    .bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_pre      <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_z        <= 1'b0;
      r_z_active <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_pre      <= w_pre_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_z        <= w_z_next;
      r_z_active <= w_z_active_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  // Outputs are registered, so each branch computes the bit that Z will
  // carry after the edge; r_pre / r_shift hold the bits still to be sent.
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_pre_next      = r_pre;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    w_z_next        = r_z;
    w_z_active_next = r_z_active;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_frame_end     = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_z_next        = 1'b0;
        w_z_active_next = 1'b0;
        w_busy_next     = 1'b0;
        if (bus.in_valid) begin
          w_state_next    = PRE;
          w_bit_cnt_next  = '0;
          w_z_next        = PRE_PATTERN[PRE_W-1];
          w_pre_next      = PRE_PATTERN << 1;
          w_shift_next    = bus.in_data;
          w_parity_next   = ^bus.in_data;
          w_z_active_next = 1'b1;
          w_busy_next     = 1'b1;
        end
      end
      PRE: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == PRE_LAST) begin
            w_state_next   = DATA;
            w_bit_cnt_next = '0;
            w_z_next       = r_shift[DATA_W-1];
            w_shift_next   = r_shift << 1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
            w_z_next       = r_pre[PRE_W-1];
            w_pre_next     = r_pre << 1;
          end
        end
      end
      DATA: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == DATA_LAST) begin
            if (PARITY_EN != 0) begin
              w_state_next   = PARITY;
              w_bit_cnt_next = '0;
              w_z_next       = r_parity;
            end else begin
              w_frame_end = 1'b1;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
            w_z_next       = r_shift[DATA_W-1];
            w_shift_next   = r_shift << 1;
          end
        end
      end
      PARITY: begin
        if (w_bit_tick) begin
          w_frame_end = 1'b1;
        end
      end
      GAP: begin
        if (w_bit_tick) begin
          if (r_bit_cnt == GAP_LAST) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
            w_busy_next    = 1'b0;
            w_done_next    = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Last frame bit finished: go to the gap, or straight to idle with done.
    if (w_frame_end) begin
      w_bit_cnt_next  = '0;
      w_z_next        = 1'b0;
      w_z_active_next = 1'b0;
      if (GAP_BITS > 0) begin
        w_state_next = GAP;
        w_busy_next  = 1'b1;
      end else begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
      end
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.Z        = r_z;
  assign bus.z_active = r_z_active;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: three transmitter instances (defaults, 3 clks/bit,
// no parity + no gap) sharing clock, reset and word stimulus; a selector
// routes the handshake to one instance at a time. Expected serial bits are
// queued when a word is offered and popped while z_active is high.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tb_valid = 1'b0;
  logic [7:0] tb_data = 8'h00;
  int         sel = 0;
  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  logic       exp_q[$];

  logic m_z, m_act, m_busy, m_done, m_ready;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.DATA_W(8)) if_a ();
  seq_pattern_tx_if #(.DATA_W(8)) if_b ();
  seq_pattern_tx_if #(.DATA_W(8)) if_c ();

  assign if_a.in_valid = tb_valid && (sel == 0);
  assign if_b.in_valid = tb_valid && (sel == 1);
  assign if_c.in_valid = tb_valid && (sel == 2);
  assign if_a.in_data  = tb_data;
  assign if_b.in_data  = tb_data;
  assign if_c.in_data  = tb_data;

  seq_pattern_tx dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  seq_pattern_tx #(.CLKS_PER_BIT(3)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  seq_pattern_tx #(.PARITY_EN(0), .GAP_BITS(0)) dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

  always_comb begin
    m_z = if_a.Z; m_act = if_a.z_active; m_busy = if_a.busy; m_done = if_a.done; m_ready = if_a.in_ready;
    case (sel)
      1: begin m_z = if_b.Z; m_act = if_b.z_active; m_busy = if_b.busy; m_done = if_b.done; m_ready = if_b.in_ready; end
      2: begin m_z = if_c.Z; m_act = if_c.z_active; m_busy = if_c.busy; m_done = if_c.done; m_ready = if_c.in_ready; end
      default: ;
    endcase
  end

  // Inputs change 1 time unit after posedge, so at negedge this predicts acceptance.
  always @(negedge clk) if (reset_n && tb_valid && m_ready) acc_cnt++;

  task automatic push_expected(input logic [7:0] d, input int clks, input int par);
    logic [3:0] pre;
    logic       p;
    pre = 4'b1011;
    p = ^d;
    for (int i = 3; i >= 0; i--) for (int c = 0; c < clks; c++) exp_q.push_back(pre[i]);
    for (int i = 7; i >= 0; i--) for (int c = 0; c < clks; c++) exp_q.push_back(d[i]);
    if (par != 0) for (int c = 0; c < clks; c++) exp_q.push_back(p);
  endtask

  // Called just after the accepting edge E0; returns on the negedge where done is seen.
  task automatic watch_frame(input int clks, input int par, input int gap, input string tag);
    int   n_act, done_exp, act, done_k;
    logic e;
    n_act = (12 + par) * clks;
    done_exp = (12 + par + gap) * clks;
    act = 0;
    done_k = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (m_act === 1'b1) begin
        act++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_bit k=%0d got z_active=1 required no more frame bits", tag, k);
        end else begin
          e = exp_q.pop_front();
          if (m_z !== e) begin
            bad++;
            $display("FAIL %s z_bit k=%0d got %b required %b", tag, k, m_z, e);
          end
        end
      end else begin
        total++;
        if (m_z !== 1'b0) begin
          bad++;
          $display("FAIL %s z_inactive k=%0d got %b required 0", tag, k, m_z);
        end
      end
      if (k < done_exp) begin
        total++;
        if (m_busy !== 1'b1 || m_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s busy_ready k=%0d got busy=%b ready=%b required busy=1 ready=0", tag, k, m_busy, m_ready);
        end
      end
      if (m_done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    total++;
    if (done_k != done_exp) begin
      bad++;
      $display("FAIL %s done_cycle got %0d required %0d", tag, done_k, done_exp);
    end
    total++;
    if (act != n_act) begin
      bad++;
      $display("FAIL %s active_cycles got %0d required %0d", tag, act, n_act);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s bits_missing got %0d left required 0", tag, exp_q.size());
    end
    total++;
    if (m_busy !== 1'b0 || m_ready !== 1'b1 || m_z !== 1'b0 || m_act !== 1'b0) begin
      bad++;
      $display("FAIL %s at_done got busy=%b ready=%b z=%b act=%b required 0 1 0 0", tag, m_busy, m_ready, m_z, m_act);
    end
    $display("frame %s: done at cycle %0d, %0d active cycles", tag, done_k, act);
  endtask

  task automatic send_frame(input logic [7:0] d, input int clks, input int par, input int gap,
                            input string tag, input bit toggle);
    @(posedge clk); #1;
    tb_valid = 1'b1;
    tb_data = d;
    push_expected(d, clks, par);
    @(negedge clk);
    total++;
    if (m_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before got %b required 1", tag, m_ready);
    end
    @(posedge clk); #1;
    tb_valid = 1'b0;
    tb_data = 8'($urandom);
    if (toggle) begin
      fork
        watch_frame(clks, par, gap, tag);
        begin
          repeat (10) begin
            @(posedge clk); #1;
            tb_valid = ~tb_valid;
            tb_data = 8'($urandom);
          end
          tb_valid = 1'b0;
        end
      join
    end else begin
      watch_frame(clks, par, gap, tag);
    end
    @(negedge clk);
    total++;
    if (m_done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width got %b required 0", tag, m_done);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (m_z !== 1'b0 || m_act !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got z=%b act=%b busy=%b done=%b ready=%b required 0 0 0 0 1",
               m_z, m_act, m_busy, m_done, m_ready);
    end
    $display("reset: z=%b act=%b busy=%b done=%b ready=%b", m_z, m_act, m_busy, m_done, m_ready);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    sel = 0;
    send_frame(8'hA5, 1, 1, 1, "basic_A5", 1'b0);
    send_frame(8'h3E, 1, 1, 1, "basic_3E", 1'b0);
  endtask

  task automatic test_slow_bits();
    sel = 1;
    send_frame(8'h07, 3, 1, 1, "cpb3_07", 1'b0);
    sel = 0;
  endtask

  task automatic test_back_to_back();
    int a0;
    sel = 0;
    @(posedge clk); #1;
    a0 = acc_cnt;
    tb_valid = 1'b1;
    tb_data = 8'h00;
    push_expected(8'h00, 1, 1);
    @(posedge clk); #1;
    tb_data = 8'hFF;
    watch_frame(1, 1, 1, "b2b_00");
    push_expected(8'hFF, 1, 1);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    watch_frame(1, 1, 1, "b2b_FF");
    @(posedge clk); #1;
    total++;
    if (acc_cnt - a0 != 2) begin
      bad++;
      $display("FAIL b2b_accepts got %0d required 2", acc_cnt - a0);
    end
  endtask

  task automatic test_valid_toggle();
    int a0;
    sel = 0;
    a0 = acc_cnt;
    send_frame(8'h3C, 1, 1, 1, "toggle_3C", 1'b1);
    total++;
    if (acc_cnt - a0 != 1) begin
      bad++;
      $display("FAIL toggle_accepts got %0d required 1", acc_cnt - a0);
    end
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    @(posedge clk); #1;
    tb_valid = 1'b1;
    tb_data = 8'h96;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (m_z !== 1'b0 || m_act !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset_outputs got z=%b act=%b busy=%b done=%b ready=%b required 0 0 0 0 1",
               m_z, m_act, m_busy, m_done, m_ready);
    end
    $display("mid-frame reset: z=%b act=%b busy=%b done=%b ready=%b", m_z, m_act, m_busy, m_done, m_ready);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) begin
        bad++;
        $display("FAIL midreset_no_done got done=%b busy=%b required 0 0", m_done, m_busy);
      end
    end
    exp_q.delete();
    send_frame(8'hC3, 1, 1, 1, "after_reset_C3", 1'b0);
  endtask

  task automatic test_no_parity_no_gap();
    sel = 2;
    send_frame(8'h5A, 1, 0, 0, "nopar_nogap_5A", 1'b0);
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_bits();
    test_back_to_back();
    test_valid_toggle();
    test_reset_mid_frame();
    test_no_parity_no_gap();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial frame transmitter that produces the single-bit stream our Moore sequence-detector FSMs consume.
- Accepts one parallel word per valid/ready handshake.
- Emits a fixed preamble, then the data MSB-first, then an optional even-parity bit, then an idle gap, on one output Z.
- Sits upstream of a detector's X input; used for loopback and for driving detector testbenches.

Parameters:
- DATA_W, 8: data bits per frame (≥1).
- PRE_W, 4: preamble length in bits (≥1).
- PRE_PATTERN, 4'b1011: preamble, sent MSB-first; width PRE_W.
- CLKS_PER_BIT, 1: clk cycles each serial bit is held (≥1).
- PARITY_EN, 1: 1 appends an even-parity bit; 0 omits it.
- GAP_BITS, 1: bit-times of Z=0 after each frame (≥0).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_W  word to transmit.
- in_ready  out  1  block can accept a word this cycle.
- Z  out  1  serial output bit.
- z_active  out  1  Z carries a frame bit (preamble, data or parity).
- busy  out  1  frame or gap in progress.
- done  out  1  one-cycle pulse at end of frame (after gap).

Behaviour:
- Reset, clk domain:
  - Reset is asynchronous (reset_n low, active-low); clock is clk.
  - During reset: state=IDLE, Z=0, z_active=0, busy=0, done=0, in_ready=1, counters 0.
- Output timing: Z, z_active, busy and done are registered. in_ready is Moore-decoded as (state==IDLE).
- States and transitions:
  - IDLE → PRE on acceptance.
  - PRE → DATA after PRE_W bits.
  - DATA → PARITY after DATA_W bits, if PARITY_EN.
  - DATA (or PARITY) → GAP, or → IDLE if GAP_BITS=0.
  - GAP → IDLE after GAP_BITS bits.
- Acceptance: in_valid && in_ready sampled at edge E0.
  - in_data is latched into the shift register and parity is computed as XOR of in_data.
  - After E0: state=PRE, Z=PRE_PATTERN[PRE_W-1], z_active=1, busy=1, in_ready=0.
- Bit timing:
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - The bit timer restarts at every bit boundary; no cycle is lost between bits or between states.
- Ordering: preamble MSB→LSB, then data MSB→LSB, then the parity bit, where present.
- Even parity: the parity bit equals XOR of the DATA_W data bits.
- Active window: z_active=1 for exactly (PRE_W+DATA_W+PARITY_EN)*CLKS_PER_BIT consecutive cycles.
- GAP: Z=0, z_active=0, busy=1 for GAP_BITS*CLKS_PER_BIT cycles.
- Frame end:
  - On entry to IDLE: done=1 for one cycle, busy=0, Z=0, in_ready=1.
  - A word offered in that same cycle is accepted, giving back-to-back frames with no extra dead cycle.
- in_valid while busy: ignored (in_ready=0). in_data is sampled only at acceptance, so changes after acceptance do not affect the frame.
- In IDLE, Z=0 and z_active=0.
- Reset mid-frame: outputs go to reset values immediately (asynchronously). No done pulse. The partial frame is abandoned. After release, the first edge with in_valid=1 accepts a new word.
- Counter widths:
  - bit counter: clog2(max(PRE_W, DATA_W, GAP_BITS, 1)+1).
  - bit timer: clog2(CLKS_PER_BIT+1).
  - No wrap-around is reachable in normal operation.

Decomposition:
- Package seq_pattern_pkg:
  - state enum {IDLE, PRE, DATA, PARITY, GAP};
  - default PRE_PATTERN constant shared with the detector FSM;
  - clog2 helper function.
- Sub-module seq_bit_timer:
  - parameter CLKS_PER_BIT;
  - input restart;
  - output bit_tick, high on the last cycle of each bit.
- seq_pattern_tx holds the FSM, the shift register and the output registers.

Test Plan:
- Defaults, send 0xA5 → Z after E0+0..E0+12 = 1,0,1,1, 1,0,1,0,0,1,0,1, 0 (parity); Z=0 and z_active=0 at E0+13; done=1 only at E0+14; z_active high 13 cycles.
- CLKS_PER_BIT=3, send 0x07 → each bit held 3 cycles; parity=1; z_active high 39 cycles; done 3 cycles after the gap starts.
- Back-to-back: in_valid held high with 0x00 then 0xFF → second preamble starts the cycle after done; exactly one accept per frame; parity 0 then 0.
- in_valid toggling with changing in_data during a frame → no extra accepts; transmitted bits match the word latched at E0.
- reset_n low at data bit 3 → Z, z_active, busy, done = 0 at once; no done pulse; in_ready=1; next word after release is transmitted intact.
- PARITY_EN=0, GAP_BITS=0, send 0x5A → 12 active bits, done in the cycle immediately following the last bit, no gap cycle.
